cla16bit_with_lcu: RTL and testbench



---
 rtl/cla16bit_with_lcu.sv | 134 +++++++++++++
 tb/tb_cla16bit_with_lcu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cla16bit_with_lcu.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead slices feed a
// flattened lookahead carry unit; every result is registered on one clock.

// 4-bit lookahead slice: internal carries come straight from the group
// carry-in, and the slice exports its group propagate/generate to the LCU.
module Cla4Slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       grpP_o,
  output logic       grpG_o
);

  logic [3:0] bitP;
  logic [3:0] bitG;
  logic [3:0] bitCin;

  // XOR propagate keeps a 1+1 bit as a pure generate.
  assign bitP = a_i ^ b_i;
  assign bitG = a_i & b_i;

  assign bitCin[0] = cin_i;
  assign bitCin[1] = bitG[0] | (bitP[0] & cin_i);
  assign bitCin[2] = bitG[1] | (bitP[1] & bitG[0]) | (bitP[1] & bitP[0] & cin_i);
  assign bitCin[3] = bitG[2] | (bitP[2] & bitG[1]) | (bitP[2] & bitP[1] & bitG[0])
                   | (bitP[2] & bitP[1] & bitP[0] & cin_i);

  assign sum_o  = bitP ^ bitCin;
  assign grpP_o = &bitP;
  assign grpG_o = bitG[3] | (bitP[3] & bitG[2]) | (bitP[3] & bitP[2] & bitG[1])
                | (bitP[3] & bitP[2] & bitP[1] & bitG[0]);

endmodule

// Second-level lookahead carry unit: each group carry is a flat sum of
// products over the group P/G terms, so no carry ripples between groups.
module Lcu4 (
  input  logic [3:0] grpP_i,
  input  logic [3:0] grpG_i,
  input  logic       cin_i,
  output logic [3:0] carry_o,
  output logic       blkP_o,
  output logic       blkG_o
);

  assign carry_o[0] = grpG_i[0] | (grpP_i[0] & cin_i);
  assign carry_o[1] = grpG_i[1] | (grpP_i[1] & grpG_i[0]) | (grpP_i[1] & grpP_i[0] & cin_i);
  assign carry_o[2] = grpG_i[2] | (grpP_i[2] & grpG_i[1]) | (grpP_i[2] & grpP_i[1] & grpG_i[0])
                    | (grpP_i[2] & grpP_i[1] & grpP_i[0] & cin_i);
  assign carry_o[3] = grpG_i[3] | (grpP_i[3] & grpG_i[2]) | (grpP_i[3] & grpP_i[2] & grpG_i[1])
                    | (grpP_i[3] & grpP_i[2] & grpP_i[1] & grpG_i[0])
                    | (grpP_i[3] & grpP_i[2] & grpP_i[1] & grpP_i[0] & cin_i);

  assign blkP_o = &grpP_i;
  assign blkG_o = grpG_i[3] | (grpP_i[3] & grpG_i[2]) | (grpP_i[3] & grpP_i[2] & grpG_i[1])
                | (grpP_i[3] & grpP_i[2] & grpP_i[1] & grpG_i[0]);

endmodule

module cla16bit_with_lcu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic [3:0]  carry,
  output logic        p,
  output logic        g,
  output logic        cout
);

  logic [3:0]  grpP;
  logic [3:0]  grpG;
  logic [3:0]  grpCin;
  logic [3:0]  carry_d;
  logic [15:0] sum_d;
  logic        p_d;
  logic        g_d;

  logic [15:0] sum_q;
  logic [3:0]  carry_q;
  logic        p_q;
  logic        g_q;
  logic        cout_q;

  // Group 0 takes the external carry-in; higher groups take the LCU carries.
  assign grpCin = {carry_d[2:0], cin};

  for (genvar k = 0; k < 4; k++) begin : gSlice
    Cla4Slice uSlice (
      .a_i    (a[4*k +: 4]),
      .b_i    (b[4*k +: 4]),
      .cin_i  (grpCin[k]),
      .sum_o  (sum_d[4*k +: 4]),
      .grpP_o (grpP[k]),
      .grpG_o (grpG[k])
    );
  end

  Lcu4 uLcu (
    .grpP_i  (grpP),
    .grpG_i  (grpG),
    .cin_i   (cin),
    .carry_o (carry_d),
    .blkP_o  (p_d),
    .blkG_o  (g_d)
  );

  // Capture all results together; reset clears them without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      g_q     <= g_d;
      cout_q  <= carry_d[3];
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;
  assign p     = p_q;
  assign g     = g_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_cla16bit_with_lcu.sv
// Scoreboard bench for the 16-bit lookahead adder: the driver pushes the
// arithmetic expectation for every captured operand set, the monitor pops
// and compares one cycle later.
module tb_cla16bit_with_lcu;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  carry;
    logic        p;
    logic        g;
    logic        cout;
  } expT;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic [3:0]  carry;
  logic        p;
  logic        g;
  logic        cout;

  expT scoreboard[$];
  int  total = 0;
  int  bad   = 0;

  cla16bit_with_lcu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .carry (carry),
    .p     (p),
    .g     (g),
    .cout  (cout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected result from plain unsigned arithmetic.
  function automatic expT modelAdd(input logic [15:0] x, input logic [15:0] y, input logic c);
    expT e;
    int  full;
    full = int'(x) + int'(y) + int'(c);
    e.sum  = full[15:0];
    e.cout = full[16];
    for (int k = 0; k < 4; k++) begin
      int m;
      int s;
      m = 1 << (4 * (k + 1));
      s = (int'(x) % m) + (int'(y) % m) + int'(c);
      e.carry[k] = (s >= m);
    end
    e.p = ((x ^ y) == 16'hFFFF);
    e.g = ((int'(x) + int'(y)) >= 65536);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one operand set and record what the next capturing edge must show.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic c);
    a   = x;
    b   = y;
    cin = c;
    scoreboard.push_back(modelAdd(x, y, c));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sum"},   32'(sum),   32'h0);
    checkOutput({tag, "_carry"}, 32'(carry), 32'h0);
    checkOutput({tag, "_p"},     32'(p),     32'h0);
    checkOutput({tag, "_g"},     32'(g),     32'h0);
    checkOutput({tag, "_cout"},  32'(cout),  32'h0);
  endtask

  // Monitor: every edge taken out of reset produces one result to compare.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        #1;
        if (scoreboard.size() == 0) begin
          checkOutput("unexpected_output", 32'(sum), 32'hDEAD_0000);
        end else begin
          expT e;
          e = scoreboard.pop_front();
          checkOutput("sum",   32'(sum),   32'(e.sum));
          checkOutput("carry", 32'(carry), 32'(e.carry));
          checkOutput("p",     32'(p),     32'(e.p));
          checkOutput("g",     32'(g),     32'(e.g));
          checkOutput("cout",  32'(cout),  32'(e.cout));
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed vectors, reset mid-stream, random burst.
  initial begin
    rst_n = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd10, 16'd15, 1'b1);
    @(negedge clk);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge clk);
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    applyStimulus(16'h1234, 16'h1111, 1'b0);

    // Reset between edges: outputs drop at once and hold through an edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_clear");
    @(posedge clk);
    #1;
    checkAllZero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h1234, 16'h1111, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Let the final result be captured, then stop further captures.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'h0);
    checkAllZero("final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
